// File: rtl/universal_register.sv
// WIDTH-bit register with synchronous clear, clock enable and an eight-way
// operation select (hold, load, shifts, rotates, arithmetic shift, increment).
module universal_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             wrap
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SLL  = 3'b010,
        MODE_SRL  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_INC  = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] next_q;
    logic             next_shift_out;
    logic             next_wrap;

    assign op = mode_t'(mode);

    // NOTE: every next_* gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_q         = q;
        next_shift_out = shift_out;
        next_wrap      = 1'b0;
        case (op)
            MODE_HOLD: ;
            MODE_LOAD: next_q = d;
            MODE_SLL: begin
                next_q         = {q[WIDTH-2:0], serial_in};
                next_shift_out = q[WIDTH-1];
            end
            MODE_SRL: begin
                next_q         = {serial_in, q[WIDTH-1:1]};
                next_shift_out = q[0];
            end
            MODE_ROL: begin
                next_q         = {q[WIDTH-2:0], q[WIDTH-1]};
                next_shift_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q         = {q[0], q[WIDTH-1:1]};
                next_shift_out = q[0];
            end
            MODE_ASR: begin
                next_q         = {q[WIDTH-1], q[WIDTH-1:1]};
                next_shift_out = q[0];
            end
            MODE_INC: begin
                // Wrap is flagged from the pre-increment value being all-ones.
                next_q    = q + WIDTH'(1);
                next_wrap = &q;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            q         <= RESET_VALUE;
            shift_out <= 1'b0;
            wrap      <= 1'b0;
        end else if (enable) begin
            q         <= next_q;
            shift_out <= next_shift_out;
            wrap      <= next_wrap;
        end else begin
            wrap      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_universal_register.sv
// Table-driven bench for universal_register at WIDTH=8, plus hand-written
// increment-wrap sequences at WIDTH=2 and WIDTH=32.
module tb_universal_register;

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       si;
        logic [7:0] exp_q;
        logic       exp_so;
        logic       exp_wrap;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear, enable, serial_in;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       shift_out, wrap;

    logic        c2, e2, s2;
    logic [2:0]  m2;
    logic [1:0]  d2, q2;
    logic        so2, w2;

    logic        c32, e32, s32;
    logic [2:0]  m32;
    logic [31:0] d32, q32;
    logic        so32, w32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clock(clock), .clear(clear), .enable(enable), .mode(mode), .d(d),
        .serial_in(serial_in), .q(q), .shift_out(shift_out), .wrap(wrap)
    );

    universal_register #(.WIDTH(2), .RESET_VALUE(2'b00)) dut2 (
        .clock(clock), .clear(c2), .enable(e2), .mode(m2), .d(d2),
        .serial_in(s2), .q(q2), .shift_out(so2), .wrap(w2)
    );

    universal_register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
        .clock(clock), .clear(c32), .enable(e32), .mode(m32), .d(d32),
        .serial_in(s32), .q(q32), .shift_out(so32), .wrap(w32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step2(input logic c, input logic e, input logic [2:0] m, input logic [1:0] dv);
        c2 = c; e2 = e; m2 = m; d2 = dv;
        @(posedge clock);
        #1;
    endtask

    task automatic step32(input logic c, input logic e, input logic [2:0] m, input logic [31:0] dv);
        c32 = c; e32 = e; m32 = m; d32 = dv;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[26];

    initial begin
        //          clr  en   mode    d      si    q      so    wrap
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 8'h96, 1'b0, 8'h96, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 8'h2D, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 8'h16, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b110, 8'h00, 1'b1, 8'hE0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 3'b010, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 3'b010, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 3'b001, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'hA6, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 8'hD3, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 8'hA6, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 8'hA7, 1'b1, 1'b0};

        clear = 1'b0; enable = 1'b0; mode = 3'b000; d = '0; serial_in = 1'b0;
        c2 = 1'b0; e2 = 1'b0; m2 = 3'b000; d2 = '0; s2 = 1'b0;
        c32 = 1'b0; e32 = 1'b0; m32 = 3'b000; d32 = '0; s32 = 1'b0;

        for (int i = 0; i < 26; i++) begin
            clear = vecs[i].clr; enable = vecs[i].en; mode = vecs[i].mode;
            d = vecs[i].d; serial_in = vecs[i].si;
            @(posedge clock);
            #1;
            check($sformatf("v%0d.q", i), 32'(q), 32'(vecs[i].exp_q));
            check($sformatf("v%0d.shift_out", i), 32'(shift_out), 32'(vecs[i].exp_so));
            check($sformatf("v%0d.wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end
        clear = 1'b0; enable = 1'b0;

        // WIDTH=2: load 10, increment twice, then idle one edge.
        step2(1'b1, 1'b0, 3'b000, 2'b00);
        check("w2.reset.q", 32'(q2), 32'h0);
        check("w2.reset.wrap", 32'(w2), 32'h0);
        step2(1'b0, 1'b1, 3'b001, 2'b10);
        check("w2.load.q", 32'(q2), 32'h2);
        step2(1'b0, 1'b1, 3'b111, 2'b00);
        check("w2.inc1.q", 32'(q2), 32'h3);
        check("w2.inc1.wrap", 32'(w2), 32'h0);
        step2(1'b0, 1'b1, 3'b111, 2'b00);
        check("w2.inc2.q", 32'(q2), 32'h0);
        check("w2.inc2.wrap", 32'(w2), 32'h1);
        step2(1'b0, 1'b0, 3'b111, 2'b00);
        check("w2.idle.q", 32'(q2), 32'h0);
        check("w2.idle.wrap", 32'(w2), 32'h0);
        check("w2.shift_out", 32'(so2), 32'h0);

        // WIDTH=32: same sequence around the 2^32 boundary.
        step32(1'b1, 1'b0, 3'b000, 32'h0);
        check("w32.reset.q", q32, 32'h0);
        step32(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFE);
        check("w32.load.q", q32, 32'hFFFF_FFFE);
        step32(1'b0, 1'b1, 3'b111, 32'h0);
        check("w32.inc1.q", q32, 32'hFFFF_FFFF);
        check("w32.inc1.wrap", 32'(w32), 32'h0);
        step32(1'b0, 1'b1, 3'b111, 32'h0);
        check("w32.inc2.q", q32, 32'h0);
        check("w32.inc2.wrap", 32'(w32), 32'h1);
        step32(1'b0, 1'b1, 3'b000, 32'h0);
        check("w32.hold.q", q32, 32'h0);
        check("w32.hold.wrap", 32'(w32), 32'h0);
        check("w32.shift_out", 32'(so32), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
